nanorv32_pipe_ctrl: RTL
=======================

# nanorv32_pipe_ctrl

Parametrised pipeline flow-control state machine for the nanorv32 core, the next generation of the core's pipeline control FSM. It sequences reset, branch refetch, data-bus waits, external stall requesters and trap entry, and drives the stall and new-PC controls of the fetch/decode/execute pipeline. It adds a data-bus timeout with trap, interrupt entry, N external stall sources and a saturating stall-cycle counter.

## Interface
- NUM_STALL_SRC, 2: number of external stall requesters (debug, coprocessor, ...), 1..8.
- BUS_TIMEOUT, 256: max WAITLD cycles with hreadyd low before a bus-error trap; 0 disables the timeout.
- TO_W, 9: timeout counter width; must hold BUS_TIMEOUT.
- CNT_W, 16: stall-cycle counter width.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- branch_taken  in  1  execute stage resolves a taken branch or jump.
- datamem_read, datamem_write  in  1 each  execute stage issues a data access.
- hreadyd  in  1  data AHB ready.
- codeif_cpu_ready_r  in  1  code interface has a valid fetched word.
- irq_req  in  1  level interrupt request, already masked.
- ext_stall_req  in  NUM_STALL_SRC  external stall requests, OR-reduced.
- stall_cnt_clr  in  1  synchronous clear of stall_cycles.
- force_stall_pstate  out  1  freeze fetch/decode.
- force_stall_data  out  1  freeze the data-side pipeline.
- force_stall_reset  out  1  reset-phase stall.
- output_new_pc  out  1  select the branch or trap target as the fetch PC.
- valid_inst  out  1  the instruction in execute is valid.
- data_access_cycle  out  1  data address phase issued this cycle.
- trap_take  out  1  one-cycle pulse on trap entry.
- trap_cause  out  2  0 = none, 1 = IRQ, 2 = bus timeout; held until the next trap.
- pstate_r  out  3  current state.
- stall_cycles  out  CNT_W  saturating count of cycles with force_stall_pstate = 1.

## Operation
- States: RESET, CONT, BRANCH, WAITLD, XSTALL, TRAP.
- Outputs are combinational from pstate_r and the inputs. Every output has a defined value in every state.
- Defaults: valid_inst = 1; all other outputs = 0.
- RESET: force_stall_pstate, force_stall_data and force_stall_reset = 1; valid_inst = 0. Next state is CONT.
- CONT, priority irq_req > branch_taken > (read|write) > |ext_stall_req:
  - irq_req: go to TRAP.
  - branch_taken: force_stall_pstate = 1, output_new_pc = 1; go to BRANCH.
  - access: data_access_cycle = 1, force_stall_data = 1; go to WAITLD.
  - ext stall: force_stall_pstate = 1; go to XSTALL.
- BRANCH: output_new_pc = 1.
  - codeif_cpu_ready_r = 1: go to CONT.
  - otherwise: force_stall_pstate = 1; stay.
- WAITLD with hreadyd = 1: clear the timeout counter, then:
  - new access: data_access_cycle = 1, force_stall_data = 1; stay (back-to-back accesses).
  - else branch_taken: as in CONT, go to BRANCH.
  - else irq_req: go to TRAP.
  - else: go to CONT.
- WAITLD with hreadyd = 0: force_stall_pstate = 1, force_stall_data = 1; the timeout counter increments.
  - When BUS_TIMEOUT ≠ 0 and the counter = BUS_TIMEOUT-1, go to TRAP with cause 2.
  - irq_req is ignored in this state.
- XSTALL: valid_inst = 0, force_stall_pstate = 1 while any request is set. Go to CONT when all requests are 0 and codeif_cpu_ready_r = 1.
- TRAP: lasts exactly one cycle.
  - trap_take = 1, output_new_pc = 1, force_stall_pstate = 1, valid_inst = 0.
  - trap_cause_r loads 2 on a timeout, else 1.
  - Next state is BRANCH.
- stall_cycles: increments on each cycle with force_stall_pstate = 1 and saturates at all-ones. stall_cnt_clr takes priority over the increment.

## Timing
- Reset values: pstate_r = RESET, timeout counter = 0, trap_cause = 0, stall_cycles = 0. All combinational outputs then take their RESET-state values.
- rst_n asserted mid-operation returns to RESET on the next evaluation with counters cleared. Any in-flight bus wait is abandoned.
- Branch penalty is at least 2 cycles: CONT → BRANCH, then exit on the first codeif_cpu_ready_r.
- A timeout fires after exactly BUS_TIMEOUT consecutive low-hreadyd cycles in WAITLD. TRAP follows on the next edge.
- Simultaneous irq_req and branch_taken in CONT: the trap wins and the branch is discarded.
- An ext_stall_req raised during BRANCH or WAITLD is sampled only on the return to CONT.

## Structure
- State encodings and trap cause codes belong in nanorv32_parameters.v: NANORV32_PSTATE_XSTALL, NANORV32_PSTATE_TRAP, NANORV32_TRAP_CAUSE_*, and NANORV32_PSTATE_MSB = 2.
- One sub-module, nanorv32_sat_counter (parameter W; inputs inc and clr). It is instantiated for stall_cycles.

## Test plan
- Reset release with codeif_cpu_ready_r = 1: RESET for 1 cycle with the three stalls = 1, then CONT with valid_inst = 1.
- branch_taken in CONT, codeif_cpu_ready_r low for 3 cycles: output_new_pc = 1 for 5 cycles total, then CONT; stall_cycles = 4.
- Three back-to-back loads, each with hreadyd = 1 immediately: data_access_cycle = 1 on 3 consecutive cycles and no force_stall_pstate.
- BUS_TIMEOUT = 4, hreadyd held 0: trap_take pulses on the 5th cycle after WAITLD entry with trap_cause = 2, then BRANCH.
- irq_req and branch_taken together in CONT: TRAP, trap_cause = 1, then BRANCH; ext_stall_req[1] pulsed for 3 cycles gives 3 XSTALL cycles with valid_inst = 0.
- stall_cycles with CNT_W = 4 saturates at 15; stall_cnt_clr together with a stall gives 0.

Source files
------------

// File: rtl/nanorv32_pipe_ctrl_pkg.sv
// Shared state encodings and trap cause codes for the nanorv32 pipeline control.
package nanorv32_pipe_ctrl_pkg;

    localparam int NANORV32_PSTATE_MSB = 2;

    typedef enum logic [NANORV32_PSTATE_MSB:0] {
        NANORV32_PSTATE_RESET  = 3'd0,
        NANORV32_PSTATE_CONT   = 3'd1,
        NANORV32_PSTATE_BRANCH = 3'd2,
        NANORV32_PSTATE_WAITLD = 3'd3,
        NANORV32_PSTATE_XSTALL = 3'd4,
        NANORV32_PSTATE_TRAP   = 3'd5
    } pstate_e;

    localparam logic [1:0] NANORV32_TRAP_CAUSE_NONE        = 2'd0;
    localparam logic [1:0] NANORV32_TRAP_CAUSE_IRQ         = 2'd1;
    localparam logic [1:0] NANORV32_TRAP_CAUSE_BUS_TIMEOUT = 2'd2;

endpackage

// File: rtl/nanorv32_pipe_ctrl_if.sv
// Pipeline-side handshake between the fetch/decode/execute datapath and its flow controller.
interface nanorv32_pipe_ctrl_if;
    logic branch_taken;
    logic datamem_read;
    logic datamem_write;
    logic hreadyd;
    logic codeif_cpu_ready_r;
    logic force_stall_pstate;
    logic force_stall_data;
    logic force_stall_reset;
    logic output_new_pc;
    logic valid_inst;
    logic data_access_cycle;

    modport master (
        output branch_taken, datamem_read, datamem_write, hreadyd, codeif_cpu_ready_r,
        input  force_stall_pstate, force_stall_data, force_stall_reset,
        input  output_new_pc, valid_inst, data_access_cycle
    );

    modport slave (
        input  branch_taken, datamem_read, datamem_write, hreadyd, codeif_cpu_ready_r,
        output force_stall_pstate, force_stall_data, force_stall_reset,
        output output_new_pc, valid_inst, data_access_cycle
    );
endinterface

// File: rtl/nanorv32_sat_counter.sv
// Up-counter that sticks at all-ones; a synchronous clear overrides counting.
module nanorv32_sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    // count up until saturated, clear wins over increment
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/nanorv32_pipe_ctrl.sv
// Pipeline flow-control FSM: reset, branch refetch, data-bus waits with timeout,
// external stall sources and trap entry, plus a stall-cycle counter.
module nanorv32_pipe_ctrl
    import nanorv32_pipe_ctrl_pkg::*;
#(
    parameter int unsigned NUM_STALL_SRC = 2,
    parameter int unsigned BUS_TIMEOUT   = 256,
    parameter int unsigned TO_W          = 9,
    parameter int unsigned CNT_W         = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    nanorv32_pipe_ctrl_if.slave          pipe,
    input  logic                         irq_req,
    input  logic [NUM_STALL_SRC-1:0]     ext_stall_req,
    input  logic                         stall_cnt_clr,
    output logic                         trap_take,
    output logic [1:0]                   trap_cause,
    output logic [NANORV32_PSTATE_MSB:0] pstate_r,
    output logic [CNT_W-1:0]             stall_cycles
);

    // Terminal count is the last low-hreadyd cycle tolerated before trapping.
    localparam bit              TO_EN   = (BUS_TIMEOUT != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_EN ? TO_W'(BUS_TIMEOUT - 1) : '0;

    pstate_e         state, state_nxt;
    logic [TO_W-1:0] to_cnt, to_cnt_nxt;
    logic [1:0]      cause_r;
    logic            to_hit;
    logic            stall_p, stall_d, stall_r, new_pc, valid, dac, take;
    logic            access, ext_any;

    assign access  = pipe.datamem_read | pipe.datamem_write;
    assign ext_any = |ext_stall_req;

    // next-state and combinational controls, defaults first
    always_comb begin
        state_nxt  = state;
        to_cnt_nxt = '0;
        to_hit     = 1'b0;
        stall_p    = 1'b0;
        stall_d    = 1'b0;
        stall_r    = 1'b0;
        new_pc     = 1'b0;
        valid      = 1'b1;
        dac        = 1'b0;
        take       = 1'b0;
        case (state)
            NANORV32_PSTATE_RESET: begin
                stall_p   = 1'b1;
                stall_d   = 1'b1;
                stall_r   = 1'b1;
                valid     = 1'b0;
                state_nxt = NANORV32_PSTATE_CONT;
            end
            NANORV32_PSTATE_CONT: begin
                if (irq_req) begin
                    state_nxt = NANORV32_PSTATE_TRAP;
                end else if (pipe.branch_taken) begin
                    stall_p   = 1'b1;
                    new_pc    = 1'b1;
                    state_nxt = NANORV32_PSTATE_BRANCH;
                end else if (access) begin
                    dac       = 1'b1;
                    stall_d   = 1'b1;
                    state_nxt = NANORV32_PSTATE_WAITLD;
                end else if (ext_any) begin
                    stall_p   = 1'b1;
                    state_nxt = NANORV32_PSTATE_XSTALL;
                end
            end
            NANORV32_PSTATE_BRANCH: begin
                new_pc = 1'b1;
                if (pipe.codeif_cpu_ready_r) begin
                    state_nxt = NANORV32_PSTATE_CONT;
                end else begin
                    stall_p = 1'b1;
                end
            end
            NANORV32_PSTATE_WAITLD: begin
                if (pipe.hreadyd) begin
                    if (access) begin
                        dac     = 1'b1;
                        stall_d = 1'b1;
                    end else if (pipe.branch_taken) begin
                        stall_p   = 1'b1;
                        new_pc    = 1'b1;
                        state_nxt = NANORV32_PSTATE_BRANCH;
                    end else if (irq_req) begin
                        state_nxt = NANORV32_PSTATE_TRAP;
                    end else begin
                        state_nxt = NANORV32_PSTATE_CONT;
                    end
                end else begin
                    // irq_req is deliberately not looked at while the bus is busy
                    stall_p    = 1'b1;
                    stall_d    = 1'b1;
                    to_cnt_nxt = to_cnt + TO_W'(1);
                    if (TO_EN && (to_cnt == TO_LAST)) begin
                        to_hit     = 1'b1;
                        to_cnt_nxt = '0;
                        state_nxt  = NANORV32_PSTATE_TRAP;
                    end
                end
            end
            NANORV32_PSTATE_XSTALL: begin
                valid   = 1'b0;
                stall_p = ext_any;
                if (!ext_any && pipe.codeif_cpu_ready_r) begin
                    state_nxt = NANORV32_PSTATE_CONT;
                end
            end
            NANORV32_PSTATE_TRAP: begin
                take      = 1'b1;
                new_pc    = 1'b1;
                stall_p   = 1'b1;
                valid     = 1'b0;
                state_nxt = NANORV32_PSTATE_BRANCH;
            end
            default: begin
                state_nxt = NANORV32_PSTATE_RESET;
            end
        endcase
    end

    // state, bus-wait timer and trap cause registers; cause latches on trap entry
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= NANORV32_PSTATE_RESET;
            to_cnt  <= '0;
            cause_r <= NANORV32_TRAP_CAUSE_NONE;
        end else begin
            state  <= state_nxt;
            to_cnt <= to_cnt_nxt;
            if (state_nxt == NANORV32_PSTATE_TRAP) begin
                cause_r <= to_hit ? NANORV32_TRAP_CAUSE_BUS_TIMEOUT : NANORV32_TRAP_CAUSE_IRQ;
            end
        end
    end

    nanorv32_sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (stall_p),
        .clr   (stall_cnt_clr),
        .count (stall_cycles)
    );

    assign pipe.force_stall_pstate = stall_p;
    assign pipe.force_stall_data   = stall_d;
    assign pipe.force_stall_reset  = stall_r;
    assign pipe.output_new_pc      = new_pc;
    assign pipe.valid_inst         = valid;
    assign pipe.data_access_cycle  = dac;
    assign trap_take               = take;
    assign trap_cause              = cause_r;
    assign pstate_r                = state;

endmodule
